// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix command sequencer: driver register
// addresses, sequencer states and the 16-bit command word format.
package led_matrix_pkg;

  typedef logic [15:0] cmd_word_t;

  localparam logic [3:0] REG_DIGIT0    = 4'h1;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  localparam int NUM_ROWS = 8;

  typedef enum logic [2:0] {
    POR_WAIT,
    INIT,
    IDLE,
    INTENS,
    FETCH,
    LOAD,
    SEND
  } seq_state_e;

  // Driver words carry a zero top nibble, the register address, then the value.
  function automatic cmd_word_t make_cmd(input logic [3:0] addr, input logic [7:0] value);
    return {4'h0, addr, value};
  endfunction

endpackage

// File: rtl/led_matrix_sequencer_if.sv
// Bus between the sequencer, the frame-buffer read port and the word-level
// SPI transmitter.
interface led_matrix_sequencer_if;

  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic [2:0]  row_addr;
  logic [7:0]  row_data;

  modport master (
    output tx_valid,
    output tx_data,
    output row_addr,
    input  tx_ready,
    input  row_data
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  row_addr,
    output tx_ready,
    output row_data
  );

endinterface

// File: rtl/led_frame_timer.sv
// Refresh tick generator: a reloading down-counter that pulses tick once every
// FRAME_CYCLES clocks while enabled.
module led_frame_timer #(
  parameter int FRAME_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CountW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 2;

  logic [CountW-1:0] count_q, count_d;

  // Counter reloads at zero and ticks one step earlier, so the period is
  // exactly FRAME_CYCLES clocks from the first reload onwards.
  always_comb begin
    count_d = count_q;
    if (!en) begin
      count_d = '0;
    end else if (count_q == '0) begin
      count_d = CountW'(FRAME_CYCLES - 1);
    end else begin
      count_d = count_q - 1'b1;
    end
  end

  assign tick = en && (count_q == CountW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_matrix_sequencer.sv
// Command sequencer for a MAX7219-class 8x8 LED matrix driver: power-up settle,
// init sequence, then periodic row refresh from the frame buffer.
module led_matrix_sequencer
  import led_matrix_pkg::*;
#(
  parameter int POR_CYCLES   = 1024,
  parameter int FRAME_CYCLES = 50000,
  parameter int SCAN_LIMIT   = 7
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic [3:0]                    intensity,
  led_matrix_sequencer_if.master        bus,
  output logic                          init_done,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int PorW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;

  seq_state_e      state_q, state_d;
  logic [PorW-1:0] porCount_q, porCount_d;
  logic [2:0]      initIdx_q, initIdx_d;
  logic [2:0]      rowIdx_q, rowIdx_d;
  logic [2:0]      rowAddr_q, rowAddr_d;
  logic            txValid_q, txValid_d;
  cmd_word_t       txData_q, txData_d;
  logic [3:0]      intensity_q, intensity_d;
  logic            pending_q, pending_d;
  logic            initDone_q, initDone_d;
  logic            frameDone_q, frameDone_d;
  logic            tick;
  logic            consume;
  cmd_word_t       initWord;

  led_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (initDone_q),
    .tick (tick)
  );

  always_comb begin
    initWord = make_cmd(REG_DISPTEST, 8'h00);
    case (initIdx_q)
      3'd0:    initWord = make_cmd(REG_SHUTDOWN, 8'h01);
      3'd1:    initWord = make_cmd(REG_DECODE, 8'h00);
      3'd2:    initWord = make_cmd(REG_SCANLIM, 8'(SCAN_LIMIT));
      3'd3:    initWord = make_cmd(REG_INTENSITY, {4'h0, intensity});
      default: initWord = make_cmd(REG_DISPTEST, 8'h00);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    porCount_d  = porCount_q;
    initIdx_d   = initIdx_q;
    rowIdx_d    = rowIdx_q;
    txValid_d   = txValid_q;
    txData_d    = txData_q;
    intensity_d = intensity_q;
    initDone_d  = initDone_q;
    frameDone_d = 1'b0;
    consume     = 1'b0;

    case (state_q)
      POR_WAIT: begin
        if (porCount_q == PorW'(POR_CYCLES - 1)) begin
          state_d = INIT;
        end else begin
          porCount_d = porCount_q + 1'b1;
        end
      end

      // Each word is raised in its own cycle and dropped on acceptance.
      INIT: begin
        if (!txValid_q) begin
          txValid_d = 1'b1;
          txData_d  = initWord;
          if (initIdx_q == 3'd3) begin
            intensity_d = intensity;
          end
        end else if (bus.tx_ready) begin
          txValid_d = 1'b0;
          if (initIdx_q == 3'd4) begin
            initDone_d = 1'b1;
            state_d    = IDLE;
          end else begin
            initIdx_d = initIdx_q + 3'd1;
          end
        end
      end

      IDLE: begin
        if (pending_q && ena) begin
          consume  = 1'b1;
          rowIdx_d = 3'd0;
          if (intensity != intensity_q) begin
            txValid_d = 1'b1;
            txData_d  = make_cmd(REG_INTENSITY, {4'h0, intensity});
            state_d   = INTENS;
          end else begin
            state_d = FETCH;
          end
        end
      end

      INTENS: begin
        if (txValid_q && bus.tx_ready) begin
          txValid_d   = 1'b0;
          intensity_d = txData_q[3:0];
          state_d     = ena ? FETCH : IDLE;
        end
      end

      FETCH: begin
        state_d = ena ? LOAD : IDLE;
      end

      LOAD: begin
        if (ena) begin
          txValid_d = 1'b1;
          txData_d  = make_cmd(REG_DIGIT0 + {1'b0, rowIdx_q}, bus.row_data);
          state_d   = SEND;
        end else begin
          state_d = IDLE;
        end
      end

      // A finished last row completes the frame even if ena has just dropped.
      SEND: begin
        if (txValid_q && bus.tx_ready) begin
          txValid_d = 1'b0;
          if (rowIdx_q == 3'(NUM_ROWS - 1)) begin
            frameDone_d = 1'b1;
            state_d     = IDLE;
          end else if (!ena) begin
            state_d = IDLE;
          end else begin
            rowIdx_d = rowIdx_q + 3'd1;
            state_d  = FETCH;
          end
        end
      end

      default: state_d = POR_WAIT;
    endcase
  end

  // A tick that lands while a request is already queued is simply lost.
  always_comb begin
    pending_d = pending_q;
    if (consume) begin
      pending_d = 1'b0;
    end else if (tick) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    rowAddr_d = rowAddr_q;
    if (state_d == FETCH) begin
      rowAddr_d = rowIdx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= POR_WAIT;
      porCount_q  <= '0;
      initIdx_q   <= '0;
      rowIdx_q    <= '0;
      rowAddr_q   <= '0;
      txValid_q   <= 1'b0;
      txData_q    <= '0;
      intensity_q <= '0;
      pending_q   <= 1'b0;
      initDone_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      porCount_q  <= porCount_d;
      initIdx_q   <= initIdx_d;
      rowIdx_q    <= rowIdx_d;
      rowAddr_q   <= rowAddr_d;
      txValid_q   <= txValid_d;
      txData_q    <= txData_d;
      intensity_q <= intensity_d;
      pending_q   <= pending_d;
      initDone_q  <= initDone_d;
      frameDone_q <= frameDone_d;
    end
  end

  assign bus.tx_valid = txValid_q;
  assign bus.tx_data  = txData_q;
  assign bus.row_addr = rowAddr_q;
  assign init_done    = initDone_q;
  assign frame_done   = frameDone_q;
  assign busy         = (state_q != IDLE);

endmodule
